// File: rtl/logicunit_seq_pkg.sv
// Shared definitions for the multi-cycle logic unit: op encodings and FSM states.
package logicunit_seq_pkg;

   localparam logic [1:0] LU_AND = 2'b00;
   localparam logic [1:0] LU_OR  = 2'b01;
   localparam logic [1:0] LU_NOR = 2'b10;
   localparam logic [1:0] LU_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logicunit_seq_logic_slice.sv
// Combinational SLICE-bit bitwise op unit; one instance is reused across the word.
module logic_slice
   import logicunit_seq_pkg::*;
#(
   parameter int SLICE = 8
) (
   output logic [SLICE-1:0] out,
   input  logic [SLICE-1:0] A,
   input  logic [SLICE-1:0] B,
   input  logic [1:0]       control
);

   always_comb begin
      out = '0;
      case (control)
         LU_AND:  out = A & B;
         LU_OR:   out = A | B;
         LU_NOR:  out = ~(A | B);
         LU_XOR:  out = A ^ B;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/logicunit_seq.sv
// Multi-cycle bitwise logic unit: walks WIDTH-bit operands SLICE bits per cycle
// through one logic_slice, with start/busy/done handshake and a zero flag.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | computing slice idx, one per cycle
// DONE  | result valid for one cycle; start here begins the next op
module logicunit_seq
   import logicunit_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   state_t           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [1:0]       ctl_reg;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_next;
   logic [BW-1:0]    base;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_out;

   always_comb begin
      base        = BW'(idx) * BW'(SLICE);
      slice_a     = a_reg[base +: SLICE];
      slice_b     = b_reg[base +: SLICE];
      result_next = result;
      result_next[base +: SLICE] = slice_out;
   end

   logic_slice #(.SLICE(SLICE)) u_slice (
      .out     (slice_out),
      .A       (slice_a),
      .B       (slice_b),
      .control (ctl_reg)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         ctl_reg <= '0;
         result  <= '0;
         out     <= '0;
         zero    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg   <= A;
                  b_reg   <= B;
                  ctl_reg <= control;
                  result  <= '0;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               result <= result_next;
               if (idx == LAST) begin
                  // out/zero only move here so the previous result stays visible while busy
                  out   <= result_next;
                  zero  <= (result_next == '0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logicunit_seq.sv
// Directed bench for logicunit_seq: 32/8 main config plus NSLICE=1 and 1-bit-slice configs.
module tb_logicunit_seq;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   logic        start_m = 1'b0, busy_m, done_m, zero_m;
   logic [31:0] a_m = '0, b_m = '0, out_m;
   logic [1:0]  c_m = '0;

   logic        start_o = 1'b0, busy_o, done_o, zero_o;
   logic [31:0] a_o = '0, b_o = '0, out_o;
   logic [1:0]  c_o = '0;

   logic        start_b = 1'b0, busy_b, done_b, zero_b;
   logic [3:0]  a_b = '0, b_b = '0, out_b;
   logic [1:0]  c_b = '0;

   int checks   = 0;
   int failures = 0;
   logic [31:0] last_out = '0;

   logicunit_seq #(.WIDTH(32), .SLICE(8)) u_main (
      .clock(clock), .reset(reset), .start(start_m), .A(a_m), .B(b_m), .control(c_m),
      .busy(busy_m), .done(done_m), .out(out_m), .zero(zero_m));

   logicunit_seq #(.WIDTH(32), .SLICE(32)) u_one (
      .clock(clock), .reset(reset), .start(start_o), .A(a_o), .B(b_o), .control(c_o),
      .busy(busy_o), .done(done_o), .out(out_o), .zero(zero_o));

   logicunit_seq #(.WIDTH(4), .SLICE(1)) u_bit (
      .clock(clock), .reset(reset), .start(start_b), .A(a_b), .B(b_b), .control(c_b),
      .busy(busy_b), .done(done_b), .out(out_b), .zero(zero_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model4(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] c);
      case (c)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   // Starts at a negedge, ends at the negedge of the DONE cycle with start low.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c, input logic [31:0] exp, input logic expz,
                         input bit hold, input bit disturb);
      a_m = a; b_m = b; c_m = c; start_m = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (!hold || k == 3) start_m = 1'b0;
         if (disturb && k == 0) begin a_m = '0; c_m = 2'b00; end
         check({tag, "_busy"}, {31'd0, busy_m}, 32'd1);
         check({tag, "_nodone"}, {31'd0, done_m}, 32'd0);
         check({tag, "_outhold"}, out_m, last_out);
      end
      @(negedge clock);
      check({tag, "_done"}, {31'd0, done_m}, 32'd1);
      check({tag, "_busylow"}, {31'd0, busy_m}, 32'd0);
      check({tag, "_out"}, out_m, exp);
      check({tag, "_zero"}, {31'd0, zero_m}, {31'd0, expz});
      last_out = exp;
   endtask

   initial begin
      logic [3:0] ra, rb, re;
      logic [1:0] rc;

      repeat (2) @(negedge clock);
      check("rst_busy", {31'd0, busy_m}, 32'd0);
      check("rst_done", {31'd0, done_m}, 32'd0);
      check("rst_out",  out_m, 32'd0);
      check("rst_zero", {31'd0, zero_m}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      run_op("and1", 32'hF0F01234, 32'hFF0000FF, 2'b00, 32'hF0000034, 1'b0, 0, 0);
      run_op("or0",  32'h00000000, 32'h00000000, 2'b01, 32'h00000000, 1'b1, 0, 0);
      run_op("nor",  32'h0F0F0F0F, 32'hF0F00000, 2'b10, 32'h0000F0F0, 1'b0, 0, 0);
      run_op("xor_dist", 32'hAAAAAAAA, 32'hFFFFFFFF, 2'b11, 32'h55555555, 1'b0, 0, 1);

      @(negedge clock);
      run_op("hold", 32'h12340000, 32'h00005678, 2'b01, 32'h12345678, 1'b0, 1, 0);
      @(negedge clock);
      check("hold_norestart_busy", {31'd0, busy_m}, 32'd0);
      check("hold_single_done", {31'd0, done_m}, 32'd0);

      run_op("b2b_a", 32'hFFFF0000, 32'h0F0F0F0F, 2'b00, 32'h0F0F0000, 1'b0, 0, 0);
      run_op("b2b_b", 32'h0F0F0000, 32'h0F0F0000, 2'b11, 32'h00000000, 1'b1, 0, 0);
      run_op("pre_rst", 32'hDEADBEEF, 32'h00000000, 2'b01, 32'hDEADBEEF, 1'b0, 0, 0);

      // Reset during the second BUSY cycle
      a_m = 32'h0000FFFF; b_m = 32'h0000FFFF; c_m = 2'b00; start_m = 1'b1;
      @(negedge clock); start_m = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy_m}, 32'd0);
      check("mid_rst_done", {31'd0, done_m}, 32'd0);
      check("mid_rst_out",  out_m, 32'd0);
      check("mid_rst_zero", {31'd0, zero_m}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      last_out = '0;
      repeat (4) begin
         @(negedge clock);
         check("post_rst_nodone", {31'd0, done_m}, 32'd0);
      end
      run_op("and_after_rst", 32'hFFFFFFFF, 32'h12345678, 2'b00, 32'h12345678, 1'b0, 0, 0);

      // NSLICE = 1
      a_o = 32'h1; b_o = 32'h1; c_o = 2'b11; start_o = 1'b1;
      @(negedge clock); start_o = 1'b0;
      check("one_busy", {31'd0, busy_o}, 32'd1);
      check("one_nodone", {31'd0, done_o}, 32'd0);
      @(negedge clock);
      check("one_done", {31'd0, done_o}, 32'd1);
      check("one_out",  out_o, 32'd0);
      check("one_zero", {31'd0, zero_o}, 32'd1);
      a_o = 32'hF0F0F0F0; b_o = 32'h0F0F0000; start_o = 1'b1;
      @(negedge clock); start_o = 1'b0;
      check("one2_busy", {31'd0, busy_o}, 32'd1);
      @(negedge clock);
      check("one2_done", {31'd0, done_o}, 32'd1);
      check("one2_out",  out_o, 32'hFFFFF0F0);
      check("one2_zero", {31'd0, zero_o}, 32'd0);
      @(negedge clock);

      // WIDTH=4, SLICE=1: directed NOR then random ops against the model
      for (int n = 0; n < 33; n++) begin
         if (n == 0) begin
            ra = 4'b0101; rb = 4'b0011; rc = 2'b10; re = 4'b1000;
         end else begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 2'($urandom_range(0, 3));
            re = model4(ra, rb, rc);
         end
         a_b = ra; b_b = rb; c_b = rc; start_b = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            start_b = 1'b0;
            if (k == 0) begin a_b = ~ra; b_b = ~rb; end
            check("bit_busy", {31'd0, busy_b}, 32'd1);
            check("bit_nodone", {31'd0, done_b}, 32'd0);
         end
         @(negedge clock);
         check("bit_done", {31'd0, done_b}, 32'd1);
         check("bit_out",  {28'd0, out_b}, {28'd0, re});
         check("bit_zero", {31'd0, zero_b}, {31'd0, (re == 4'd0)});
      end

      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
